// File: rtl/prefix_accumulator.sv
// Streaming packet accumulator built around a 32-bit Kogge-Stone prefix adder.
// Adder carry-outs extend the running sum through a small carry counter.

module prefix_adder (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] s,
    output logic        cout
);

    logic [31:0] g0;
    logic [31:0] p0;
    logic [31:0] g_all;
    logic [31:0] p_all;
    logic [32:0] carry;

    assign g0 = a & b;
    assign p0 = a ^ b;

    // Each level doubles the span of every group generate/propagate.
    for (genvar l = 0; l < 5; l++) begin : gen_lvl
        localparam int D = 1 << l;
        localparam logic [31:0] LOW = (32'd1 << D) - 32'd1;

        logic [31:0] g_in;
        logic [31:0] p_in;
        logic [31:0] g_out;
        logic [31:0] p_out;

        if (l == 0) begin : gen_first
            assign g_in = g0;
            assign p_in = p0;
        end else begin : gen_chain
            assign g_in = gen_lvl[l-1].g_out;
            assign p_in = gen_lvl[l-1].p_out;
        end

        assign g_out = g_in | (p_in & (g_in << D));
        assign p_out = p_in & ((p_in << D) | LOW);
    end

    assign g_all = gen_lvl[4].g_out;
    assign p_all = gen_lvl[4].p_out;

    assign carry = {g_all | (p_all & {32{cin}}), cin};
    assign s     = p0 ^ carry[31:0];
    assign cout  = carry[32];

endmodule

module prefix_accumulator #(
    parameter int CARRY_BITS = 8,
    parameter int COUNT_BITS = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_data,
    input  logic                       in_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [32+CARRY_BITS-1:0]   out_sum,
    output logic [COUNT_BITS-1:0]      out_count,
    output logic                       out_ovf
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [31:0]            acc_lo;
    logic [CARRY_BITS-1:0]  acc_hi;
    logic [COUNT_BITS-1:0]  count;
    logic                   ovf;

    logic [31:0]            add_sum;
    logic                   add_cout;
    logic [CARRY_BITS-1:0]  hi_nxt;
    logic [COUNT_BITS-1:0]  cnt_nxt;
    logic                   ovf_nxt;
    logic                   accept;
    logic                   done_hs;

    prefix_adder u_adder (
        .a    (acc_lo),
        .b    (in_data),
        .cin  (1'b0),
        .s    (add_sum),
        .cout (add_cout)
    );

    assign hi_nxt  = acc_hi + CARRY_BITS'(add_cout);
    assign ovf_nxt = ovf | (add_cout & (&acc_hi));
    assign cnt_nxt = (&count) ? count : count + COUNT_BITS'(1);

    // Handshake flags are decoded from state only; inputs just qualify them.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        done_hs   = 1'b0;
        unique case (state)
            IDLE, ACCUM: begin
                in_ready = 1'b1;
                accept   = in_valid;
                if (in_valid) begin
                    state_nxt = in_last ? DONE : ACCUM;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                done_hs   = out_ready;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_lo    <= '0;
            acc_hi    <= '0;
            count     <= '0;
            ovf       <= 1'b0;
            out_sum   <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
        end else if (accept) begin
            acc_lo <= add_sum;
            acc_hi <= hi_nxt;
            count  <= cnt_nxt;
            ovf    <= ovf_nxt;
            if (in_last) begin
                out_sum   <= {hi_nxt, add_sum};
                out_count <= cnt_nxt;
                out_ovf   <= ovf_nxt;
            end
        end else if (done_hs) begin
            acc_lo <= '0;
            acc_hi <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end
    end

endmodule
